// File: rtl/uninasoc_pkg.sv
// Shared SoC definitions: GPIO defaults, register offsets, AXI response codes
// and the GPIO slave's internal types.
package uninasoc_pkg;

  localparam int unsigned NUM_GPIO_IN          = 16;
  localparam int unsigned NUM_GPIO_OUT         = 16;
  localparam int unsigned GPIO_DEBOUNCE_CYCLES = 4;

  localparam logic [31:0] GPIO_IN_OFFSET         = 32'h00;
  localparam logic [31:0] GPIO_OUT_OFFSET        = 32'h04;
  localparam logic [31:0] GPIO_OUT_SET_OFFSET    = 32'h08;
  localparam logic [31:0] GPIO_OUT_CLR_OFFSET    = 32'h0C;
  localparam logic [31:0] GPIO_RISE_EN_OFFSET    = 32'h10;
  localparam logic [31:0] GPIO_FALL_EN_OFFSET    = 32'h14;
  localparam logic [31:0] GPIO_IRQ_STATUS_OFFSET = 32'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index taken from addr[4:2]; slot 7 is the unmapped hole.
  typedef enum logic [2:0] {
    REG_IN         = 3'd0,
    REG_OUT        = 3'd1,
    REG_OUT_SET    = 3'd2,
    REG_OUT_CLR    = 3'd3,
    REG_RISE_EN    = 3'd4,
    REG_FALL_EN    = 3'd5,
    REG_IRQ_STATUS = 3'd6,
    REG_UNMAPPED   = 3'd7
  } gpio_reg_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } gpio_wr_state_e;

  typedef enum logic [1:0] {
    R_BOOT = 2'd0,
    R_IDLE = 2'd1,
    R_DATA = 2'd2
  } gpio_rd_state_e;

  typedef struct packed {
    gpio_wr_state_e wr_state;
    gpio_rd_state_e rd_state;
  } gpio_dbg_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mask[8*b +: 8] = 8'hFF;
    end
    return mask;
  endfunction

endpackage

// File: rtl/uninasoc_gpio_if.sv
// AXI-Lite slave port bundle for the GPIO peripheral.
// Every channel transfers on a rising edge where valid && ready; once raised,
// valid and its payload hold until that edge, and ready may depend on valid.
interface uninasoc_gpio_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/gpio_debounce.sv
// One input pin: 2-FF synchroniser, stability-count debouncer, registered
// level and single-cycle rise/fall strobes aligned with the level update.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic stable;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable = sync;
  end else begin : g_filter
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          stable_q;

    // The counter only runs while sync disagrees with the accepted value.
    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        stable_q <= 1'b0;
        cnt      <= '0;
      end else if (sync == stable_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable_q <= sync;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign stable = stable_q;
  end

  // level is the IN register bit; the strobes fire in the cycle before it moves.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) level <= 1'b0;
    else           level <= stable;
  end

  assign rise = stable & ~level;
  assign fall = ~stable & level;

endmodule

// File: rtl/uninasoc_gpio.sv
// AXI-Lite GPIO slave: debounced inputs, atomic set/clear outputs and
// edge interrupts with write-1-to-clear status.
module uninasoc_gpio
  import uninasoc_pkg::*;
#(
  parameter int unsigned          NUM_IN          = NUM_GPIO_IN,
  parameter int unsigned          NUM_OUT         = NUM_GPIO_OUT,
  parameter int unsigned          DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
  parameter logic [NUM_OUT-1:0]   OUT_RESET       = '0
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  uninasoc_gpio_if.slave     s_axilite,
  input  logic [NUM_IN-1:0]  gpio_in_i,
  output logic [NUM_OUT-1:0] gpio_out_o,
  output logic               irq_o,
  output gpio_dbg_t          dbg_o
);

  gpio_wr_state_e wr_state, wr_next;
  gpio_rd_state_e rd_state, rd_next;
  logic           wr_hs, rd_hs;
  logic           bvalid, arready, rvalid;

  gpio_reg_e      wr_idx, rd_idx;
  logic [31:0]    wmask, wbits, rd_value;

  logic [NUM_OUT-1:0] out_q;
  logic [NUM_IN-1:0]  level, rise, fall, events;
  logic [NUM_IN-1:0]  rise_en, fall_en, status, status_next;
  logic [1:0]         bresp_q, rresp_q;
  logic [31:0]        rdata_q;

  // ---------------- input pins ----------------
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_i (clock_i),
      .reset_ni(reset_ni),
      .pin     (gpio_in_i[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign events = (rise & rise_en) | (fall & fall_en);

  // ---------------- write channel FSM ----------------
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) wr_state <= W_IDLE;
    else           wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (s_axilite.awvalid && s_axilite.wvalid) wr_next = W_RESP;
      W_RESP:  if (s_axilite.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    bvalid = (wr_state == W_RESP);
    wr_hs  = (wr_state == W_IDLE) && s_axilite.awvalid && s_axilite.wvalid;
  end

  // ---------------- read channel FSM ----------------
  // R_BOOT keeps arready low while reset is held and for the first cycle after.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) rd_state <= R_BOOT;
    else           rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_BOOT:  rd_next = R_IDLE;
      R_IDLE:  if (s_axilite.arvalid) rd_next = R_DATA;
      R_DATA:  if (s_axilite.rready) rd_next = R_IDLE;
      default: rd_next = R_BOOT;
    endcase
  end

  always_comb begin
    arready = (rd_state == R_IDLE);
    rvalid  = (rd_state == R_DATA);
    rd_hs   = arready && s_axilite.arvalid;
  end

  // ---------------- register file ----------------
  assign wr_idx = gpio_reg_e'(s_axilite.awaddr[4:2]);
  assign rd_idx = gpio_reg_e'(s_axilite.araddr[4:2]);
  assign wmask  = strb_to_mask(s_axilite.wstrb);
  assign wbits  = s_axilite.wdata & wmask;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_q   <= OUT_RESET;
      rise_en <= '0;
      fall_en <= '0;
      bresp_q <= RESP_OKAY;
    end else if (wr_hs) begin
      bresp_q <= (wr_idx == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
      case (wr_idx)
        REG_OUT:     out_q   <= (out_q & ~wmask[NUM_OUT-1:0]) | wbits[NUM_OUT-1:0];
        REG_OUT_SET: out_q   <= out_q | wbits[NUM_OUT-1:0];
        REG_OUT_CLR: out_q   <= out_q & ~wbits[NUM_OUT-1:0];
        REG_RISE_EN: rise_en <= (rise_en & ~wmask[NUM_IN-1:0]) | wbits[NUM_IN-1:0];
        REG_FALL_EN: fall_en <= (fall_en & ~wmask[NUM_IN-1:0]) | wbits[NUM_IN-1:0];
        default:     ;
      endcase
    end
  end

  // New events win over a W1C of the same bit in the same cycle.
  always_comb begin
    status_next = status;
    if (wr_hs && (wr_idx == REG_IRQ_STATUS)) status_next = status & ~wbits[NUM_IN-1:0];
    status_next = status_next | events;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) status <= '0;
    else           status <= status_next;
  end

  always_comb begin
    rd_value = '0;
    case (rd_idx)
      REG_IN:         rd_value[NUM_IN-1:0]  = level;
      REG_OUT:        rd_value[NUM_OUT-1:0] = out_q;
      REG_RISE_EN:    rd_value[NUM_IN-1:0]  = rise_en;
      REG_FALL_EN:    rd_value[NUM_IN-1:0]  = fall_en;
      REG_IRQ_STATUS: rd_value[NUM_IN-1:0]  = status;
      default:        rd_value = '0;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_hs) begin
      rdata_q <= rd_value;
      rresp_q <= (rd_idx == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------- outputs ----------------
  assign s_axilite.awready = wr_hs;
  assign s_axilite.wready  = wr_hs;
  assign s_axilite.bvalid  = bvalid;
  assign s_axilite.bresp   = bresp_q;
  assign s_axilite.arready = arready;
  assign s_axilite.rvalid  = rvalid;
  assign s_axilite.rdata   = rdata_q;
  assign s_axilite.rresp   = rresp_q;

  assign gpio_out_o = out_q;
  assign irq_o      = |status;
  assign dbg_o      = '{wr_state: wr_state, rd_state: rd_state};

  // Only addr[4:2] is decoded and only the low NUM_IN/NUM_OUT data bits land.
  logic unused_bits;
  assign unused_bits = ^{s_axilite.awaddr, s_axilite.araddr, wbits};

endmodule

// File: tb/tb_uninasoc_gpio.sv
// Randomised and directed bench for uninasoc_gpio with a queue scoreboard
// and a register-level reference model.
module tb_uninasoc_gpio;
  import uninasoc_pkg::*;

  localparam logic [15:0] OUT_RST = 16'hA5A5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic        irq;
  gpio_dbg_t   dbg;

  always #5 clk = ~clk;

  uninasoc_gpio_if bus ();

  uninasoc_gpio #(
    .NUM_IN(16), .NUM_OUT(16), .DEBOUNCE_CYCLES(4), .OUT_RESET(OUT_RST)
  ) dut (
    .clock_i   (clk),
    .reset_ni  (rst_n),
    .s_axilite (bus),
    .gpio_in_i (gpio_in),
    .gpio_out_o(gpio_out),
    .irq_o     (irq),
    .dbg_o     (dbg)
  );

  // ---------------- scoreboard state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  int b_mode = 0;  // 0 random, 1 hold low, 2 hold high
  int r_mode = 0;

  // reference model
  logic [15:0] in_m, out_m, rise_en_m, fall_en_m, status_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    out_m = OUT_RST; rise_en_m = '0; fall_en_m = '0; status_m = '0;
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] m;
    logic [15:0] d, mk;
    m = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = 8'hFF;
    mk = m[15:0];
    d  = data[15:0] & mk;
    case (addr[4:2])
      3'd1: out_m     = (out_m & ~mk) | d;
      3'd2: out_m     = out_m | d;
      3'd3: out_m     = out_m & ~d;
      3'd4: rise_en_m = (rise_en_m & ~mk) | d;
      3'd5: fall_en_m = (fall_en_m & ~mk) | d;
      3'd6: status_m  = status_m & ~d;
      default: ;
    endcase
    return (addr[4:2] == 3'd7) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [15:0] d;
    case (addr[4:2])
      3'd0:    d = in_m;
      3'd1:    d = out_m;
      3'd4:    d = rise_en_m;
      3'd5:    d = fall_en_m;
      3'd6:    d = status_m;
      default: d = '0;
    endcase
    return {(addr[4:2] == 3'd7) ? RESP_SLVERR : RESP_OKAY, 16'h0000, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    check("aw_wait", n < 50, 1);
    if (n < 50) exp_b_q.push_back(model_write(addr, data, strb));
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (n < 50) begin
      check("b_latency", bus.bvalid, 1);
      check("gpio_out", gpio_out, out_m);
      check("irq_after_wr", irq, |status_m);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr);
    int n;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    check("ar_wait", n < 50, 1);
    if (n < 50) exp_r_q.push_back(model_read(addr));
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    if (n < 50) check("r_latency", bus.rvalid, 1);
  endtask

  task automatic set_pins(input logic [15:0] v);
    logic [15:0] old;
    @(posedge clk); #1;
    gpio_in = v;
    repeat (10) @(posedge clk);
    #1;
    old = in_m;
    in_m = v;
    status_m = status_m | (v & ~old & rise_en_m) | (~v & old & fall_en_m);
    check("irq_after_pins", irq, |status_m);
  endtask

  task automatic drain();
    int n;
    b_mode = 2; r_mode = 2;
    n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    check("drain", exp_b_q.size() + exp_r_q.size(), 0);
  endtask

  // ---------------- response backpressure ----------------
  initial begin
    bus.bready = 1'b0; bus.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.bready = (b_mode == 2) || (b_mode == 0 && $urandom_range(0, 1) == 1);
      bus.rready = (r_mode == 2) || (r_mode == 0 && $urandom_range(0, 1) == 1);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (rst_n && bus.bvalid && bus.bready) begin
        check("b_expected", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0) begin
          eb = exp_b_q.pop_front();
          check("bresp", bus.bresp, eb);
        end
      end
      if (rst_n && bus.rvalid && bus.rready) begin
        check("r_expected", exp_r_q.size() != 0, 1);
        if (exp_r_q.size() != 0) begin
          er = exp_r_q.pop_front();
          check("rresp_rdata", {bus.rresp, bus.rdata}, er);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    model_reset();
    in_m = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", gpio_out, OUT_RST);
    check("rst_irq", irq, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_rdata", {bus.rresp, bus.rdata}, 0);
    rst_n = 1'b1;
    axi_read(32'h00);

    // atomic outputs
    axi_write(32'h04, 32'h0000_00F0, 4'hF);
    axi_write(32'h08, 32'h0000_000F, 4'hF);
    axi_write(32'h0C, 32'h0000_0030, 4'hF);
    check("atomic_out", gpio_out, 16'h00CF);
    axi_write(32'h04, 32'hFFFF_FFFF, 4'b0010);

    // glitch shorter than the debounce window
    axi_write(32'h10, 32'h1, 4'hF);
    drain();
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    gpio_in[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_irq", irq, 0);
    axi_read(32'h00);

    // pin-to-IN latency, observed through the rising-edge interrupt
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!irq && n < 20);
    check("in_latency", n, 7);
    in_m[0] = 1'b1;
    status_m[0] = 1'b1;
    axi_read(32'h00);
    axi_read(32'h18);
    axi_write(32'h18, 32'h1, 4'hF);
    check("w1c_irq", irq, 0);
    set_pins(16'h0000);
    axi_read(32'h18);

    // W1C landing on the same edge as a new rising event
    drain();
    repeat (3) @(posedge clk);
    #1;
    gpio_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.awaddr = 32'h18; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    check("collide_hs", bus.awready, 1);
    exp_b_q.push_back(model_write(32'h18, 32'h1, 4'hF));
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    in_m[0] = 1'b1;
    status_m[0] = 1'b1;
    check("collide_irq", irq, 1);
    axi_read(32'h18);
    axi_write(32'h18, 32'h1, 4'hF);

    // unmapped slot
    axi_read(32'h1C);
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF);

    // read backpressure
    drain();
    r_mode = 1;
    axi_read(32'h04);
    repeat (5) begin
      @(negedge clk);
      check("bp_rvalid", bus.rvalid, 1);
      check("bp_rdata", bus.rdata, {16'h0, out_m});
      check("bp_arready", bus.arready, 0);
    end
    r_mode = 2;
    drain();

    // simultaneous read and write
    fork
      axi_write(32'h04, 32'h0000_3C3C, 4'hF);
      axi_read(32'h10);
    join
    b_mode = 0; r_mode = 0;

    // randomised traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0:       set_pins(16'($urandom));
        1, 2:    axi_write({27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, 4'($urandom));
        default: axi_read({27'h0, 3'($urandom_range(0, 7)), 2'b00});
      endcase
    end
    drain();

    // reset while a write response is pending
    b_mode = 1;
    axi_write(32'h04, 32'h0000_1234, 4'hF);
    @(negedge clk);
    check("pre_rst_bvalid", bus.bvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_gpio_out", gpio_out, OUT_RST);
    exp_b_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_mode = 0;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_irq", irq, 0);
    axi_read(32'h04);
    axi_read(32'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uninasoc_gpio.md
# uninasoc_gpio

Parametrised AXI-Lite GPIO peripheral for the SoC peripheral bus. It supersedes fixed 16-in/16-out GPIO slaves with one block that provides:
- configurable input and output widths;
- per-input synchronisation and debouncing;
- atomic set/clear of outputs;
- rising/falling edge interrupts with write-1-to-clear status.

It sits as one AXI-Lite slave behind the peripheral-bus crossbar. `irq_o` is routed to the PLIC.

## Interface
Parameters:
- `NUM_IN`, default 16: input pin count, range 1..32.
- `NUM_OUT`, default 16: output pin count, range 1..32.
- `DEBOUNCE_CYCLES`, default 4: stable cycles required before an input change is accepted; 0 bypasses debounce.
- `OUT_RESET`, default 0: reset value of the output register, NUM_OUT bits.

Ports:
- `clock_i`, in, 1: single clock.
- `reset_ni`, in, 1: asynchronous active-low reset.
- `s_axilite_aw{addr,valid}_i / awready_o`: 32-bit address / 1 / 1. Write address channel; only addr[4:2] decoded.
- `s_axilite_w{data,strb,valid}_i / wready_o`: 32 / 4 / 1 / 1. Write data channel.
- `s_axilite_b{resp,valid}_o / bready_i`: 2 / 1 / 1. Write response channel.
- `s_axilite_ar{addr,valid}_i / arready_o`: 32 / 1 / 1. Read address channel.
- `s_axilite_r{data,resp,valid}_o / rready_i`: 32 / 2 / 1 / 1. Read data channel.
- `gpio_in_i`, in, NUM_IN: asynchronous pins.
- `gpio_out_o`, out, NUM_OUT: registered output pins.
- `irq_o`, out, 1: level interrupt, equal to |(IRQ_STATUS).

## Operation
Register map (byte offsets). Bits above NUM_IN/NUM_OUT read 0 and ignore writes.
- 0x00 IN (RO): debounced input values.
- 0x04 OUT (RW): output register, driven directly to `gpio_out_o`.
- 0x08 OUT_SET (WO): OUT |= wdata. Reads 0.
- 0x0C OUT_CLR (WO): OUT &= ~wdata. Reads 0.
- 0x10 RISE_EN (RW): per-input rising-edge interrupt enable.
- 0x14 FALL_EN (RW): per-input falling-edge interrupt enable.
- 0x18 IRQ_STATUS (RW1C): per-input latched event flags.
- 0x1C: unmapped. Responds SLVERR; reads return 0; writes have no effect. Mapped accesses respond OKAY.

Write strobes: applied per byte on RW and W1C registers. On SET/CLR, only bytes with strobe set participate.

Input path, per bit:
- 2-FF synchroniser produces `sync`; the debouncer holds `stable` and a counter `cnt`.
- If sync == stable: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
- Else: cnt <= cnt+1.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.

Edge events:
- A 0→1 change of `stable` with RISE_EN set sets STATUS[i].
- A 1→0 change of `stable` with FALL_EN set sets STATUS[i].
- Set has priority over a simultaneous W1C of the same bit.
- Clearing an enable bit does not clear STATUS.

AXI handshakes:
- Write: awready_o and wready_o are asserted together for one cycle, only when awvalid_i && wvalid_i && !bvalid_o. The register update happens on that cycle.
- bvalid_o rises the next cycle and holds until bready_i.
- Read: arready_o = !rvalid_o. rdata/rresp are registered; rvalid_o rises the cycle after the AR handshake and holds, stable, until rready_i.
- At most one outstanding read and one outstanding write. Read and write channels proceed independently in the same cycle.

## Timing
- Reset values:
  - `gpio_out_o` = OUT_RESET.
  - All other outputs 0: all ready/valid signals, `bresp`, `rresp`, `rdata`, `irq_o`.
  - RISE_EN = FALL_EN = STATUS = 0.
  - Synchronisers, `stable` and counters = 0.
- Pin to IN latency: 2 + DEBOUNCE_CYCLES + 1 cycles (2 + 1 when bypassed).
- IN to STATUS: `stable` change plus 1 cycle. `irq_o` is combinational from the STATUS flops and adds no extra cycle.
- Write to `gpio_out_o`: visible the cycle after the W handshake.
- Read data reflects register state at the AR handshake cycle.
- Reset asserted mid-transaction drops every valid immediately. Any in-flight response is discarded; the master must not expect it.

## Structure
- Add to `uninasoc_pkg`: register offset localparams (GPIO_IN_OFFSET … GPIO_IRQ_STATUS_OFFSET) and the AXI response codes RESP_OKAY and RESP_SLVERR.
- Replace the fixed NUM_GPIO_IN/NUM_GPIO_OUT in `uninasoc_pkg` with the defaults for this block's parameters.
- One sub-module, `gpio_debounce`: 1-bit synchroniser, debouncer and edge outputs, parametrised by DEBOUNCE_CYCLES. Instantiated NUM_IN times in a generate loop.

## Test plan
- **Reset:** hold reset_ni=0 with OUT_RESET=16'hA5A5 → gpio_out_o=16'hA5A5, irq_o=0, all valids 0. Read IN → 0, OKAY.
- **Atomic outputs:** write OUT=0x00F0, then OUT_SET=0x000F, then OUT_CLR=0x0030 → gpio_out_o=0x00CF. Each B response OKAY, one cycle after its handshake.
- **Debounce (DEBOUNCE_CYCLES=4):**
  - 3-cycle pulse on gpio_in_i[0] → IN[0] stays 0.
  - 4-cycle level on gpio_in_i[0] → IN[0]=1 exactly 7 cycles after the pin change.
- **Edge interrupt:**
  - RISE_EN=0x1, raise pin0 → STATUS=0x1 and irq_o=1.
  - Write IRQ_STATUS=0x1 → irq_o=0.
  - Drop pin0 with FALL_EN=0 → no event.
  - A W1C on the same cycle as a new event leaves STATUS=1.
- **Error/backpressure:**
  - Read 0x1C → rdata=0, rresp=SLVERR.
  - Hold rready_i=0 for 5 cycles → rvalid_o and rdata stay stable and arready_o stays 0.
  - Simultaneous read and write both complete.
- **Mid-operation reset:** assert reset_ni with bvalid_o high → bvalid_o=0 the same cycle and gpio_out_o returns to OUT_RESET.
